uart_rx: RTL



---
 rtl/uart_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling down-counter, and a
// 9-bit {frame_err, data} receive FIFO drained by valid/ready.
// IDLE: wait for edge | START: verify start bit | DATA: shift 8 bits | STOP: push
module uart_rx #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              div,
  output logic [7:0]                    rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          err_clear,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s1_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [8:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [8:0]       last_q, last_d, head, push_data;
  logic             fall, sample, push, push_ok, pop, valid, full;

  always_comb begin
    rx_s1_d   = rx;
    rx_s_d    = rx_s1_q;
    rx_prev_d = rx_s_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    last_d    = last_q;
    push      = 1'b0;
    push_data = {~rx_s_q, shift_q};
    fall      = rx_prev_q & ~rx_s_q;
    sample    = (cnt_q == '0);
    div_eff   = (div < DIV_W'(4)) ? DIV_W'(4) : div;

    if (state_q != IDLE) begin
      cnt_d = sample ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
          idx_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (sample) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid   = (count_q != '0);
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    pop     = valid & rx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_ok = push & (~full | pop);

    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push & full & ~pop) overrun_d = 1'b1;
    else if (err_clear)     overrun_d = 1'b0;

    if (valid) last_d = mem_q[rd_q];
    head = valid ? mem_q[rd_q] : last_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(4);
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      last_q    <= 9'd0;
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      last_q    <= last_d;
    end
  end

  assign rx_data      = head[7:0];
  assign rx_frame_err = head[8];
  assign rx_valid     = valid;
  assign overrun      = overrun_q;
  assign rx_busy      = (state_q != IDLE);
  assign fifo_count   = count_q;

endmodule
